// File: rtl/fast_read_pacer.sv
// Paces bursty fast-domain read events into single-cycle read pulses spaced GAP_CYCLES+1 apart.
// Optional build macro PACER_DROP_CNT_EN adds an 8-bit saturating drop counter output (drop_cnt).
module fast_read_pacer #(
  parameter int GAP_CYCLES = 16,
  parameter int CNT_W      = 4
) (
  input  logic             clk_fast,
  input  logic             sys_rst_n,
  input  logic             evt_valid,
  output logic             evt_ready,
  input  logic             clr_ovf,
  output logic             read,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             busy,
  output logic             ovf
`ifdef PACER_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PEND_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ZERO  = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE   = {{(GAP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   pending_q, pending_d;
  logic               read_q, read_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               accept;
  logic               drop;
  logic               emit;

  assign evt_ready   = (pending_q != PEND_MAX);
  assign accept      = evt_valid && evt_ready;
  assign drop        = evt_valid && !evt_ready;
  assign read        = read_q;
  assign pending_cnt = pending_q;
  assign busy        = busy_q;
  assign ovf         = ovf_q;

  // Next-state logic; emit decisions look only at the registered pending count.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    emit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != PEND_ZERO) begin
          emit    = 1'b1;
          state_d = ST_EMIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end
      ST_GAP: begin
        if (gap_q != GAP_ZERO) begin
          gap_d = gap_q - GAP_ONE;
        end else if (pending_q != PEND_ZERO) begin
          emit    = 1'b1;
          state_d = ST_EMIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = GAP_ZERO;
      end
    endcase
  end

  // Pending count, pulse and status next values.
  always_comb begin
    pending_d = pending_q;
    case ({accept, emit})
      2'b10:   pending_d = pending_q + PEND_ONE;
      2'b01:   pending_d = pending_q - PEND_ONE;
      default: pending_d = pending_q;
    endcase
    read_d = emit;
    busy_d = (state_d != ST_IDLE);
    // A drop on the same edge as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pacer state registers.
  always_ff @(posedge clk_fast or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      gap_q     <= GAP_ZERO;
      pending_q <= PEND_ZERO;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef PACER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt = drop_cnt_q;

  // Saturating drop counter; a drop coinciding with a clear restarts the count at one.
  always_comb begin
    if (drop && clr_ovf) begin
      drop_cnt_d = 8'd1;
    end else if (drop) begin
      drop_cnt_d = (drop_cnt_q == 8'd255) ? 8'd255 : drop_cnt_q + 8'd1;
    end else if (clr_ovf) begin
      drop_cnt_d = 8'd0;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk_fast or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_fast_read_pacer.sv
// Directed self-checking bench for fast_read_pacer with GAP_CYCLES=4, CNT_W=2.
// Define PACER_DROP_CNT_EN for the build to also check drop_cnt.
module tb_fast_read_pacer;

  localparam int GAP = 4;
  localparam int CW  = 2;

  logic          clk_fast;
  logic          sys_rst_n;
  logic          evt_valid;
  logic          evt_ready;
  logic          clr_ovf;
  logic          read;
  logic [CW-1:0] pending_cnt;
  logic          busy;
  logic          ovf;
`ifdef PACER_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int tests_run;
  int tests_failed;
  int pulse_cnt;
  int cyc;

  fast_read_pacer #(.GAP_CYCLES(GAP), .CNT_W(CW)) dut (
    .clk_fast    (clk_fast),
    .sys_rst_n   (sys_rst_n),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .clr_ovf     (clr_ovf),
    .read        (read),
    .pending_cnt (pending_cnt),
    .busy        (busy),
    .ovf         (ovf)
`ifdef PACER_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  initial clk_fast = 1'b0;
  always #5 clk_fast = ~clk_fast;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge, then sample 1 ns later and count read pulses.
  task automatic tick();
    @(posedge clk_fast);
    #1;
    cyc++;
    if (read) pulse_cnt++;
  endtask

  initial begin
    int first_idx;
    int last_idx;
    int n_pulse;
    int gap_bad;
    int pend_max;
    int p0;

    tests_run    = 0;
    tests_failed = 0;
    pulse_cnt    = 0;
    cyc          = 0;
    sys_rst_n    = 1'b0;
    evt_valid    = 1'b0;
    clr_ovf      = 1'b0;
    #23;
    sys_rst_n = 1'b1;
    #1;

    check_eq("rst_read", read, 0);
    check_eq("rst_pend", pending_cnt, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", evt_ready, 1);
`ifdef PACER_DROP_CNT_EN
    check_eq("rst_drop", drop_cnt, 0);
`endif

    // Single event
    evt_valid = 1'b1;
    tick();
    evt_valid = 1'b0;
    check_eq("s_acc_pend", pending_cnt, 1);
    check_eq("s_acc_read", read, 0);
    tick();
    check_eq("s_emit_read", read, 1);
    check_eq("s_emit_pend", pending_cnt, 0);
    check_eq("s_emit_busy", busy, 1);
    tick();
    check_eq("s_gap_read", read, 0);
    tick(); tick(); tick();
    check_eq("s_gap_busy", busy, 1);
    tick();
    check_eq("s_idle_busy", busy, 0);
    repeat (3) tick();

    // Three back-to-back events
    first_idx = -1;
    last_idx  = -1;
    n_pulse   = 0;
    gap_bad   = 0;
    pend_max  = 0;
    for (int i = 0; i < 20; i++) begin
      evt_valid = (i < 3);
      tick();
      if (pending_cnt > pend_max) pend_max = pending_cnt;
      if (read) begin
        if (first_idx < 0) first_idx = i;
        if (last_idx >= 0 && (i - last_idx) != GAP + 1) gap_bad++;
        last_idx = i;
        n_pulse++;
      end
    end
    evt_valid = 1'b0;
    check_eq("b3_first", first_idx, 1);
    check_eq("b3_pulses", n_pulse, 3);
    check_eq("b3_spacing", gap_bad, 0);
    check_eq("b3_last", last_idx, 11);
    check_eq("b3_pend_max", pend_max, 2);
    check_eq("b3_ovf", ovf, 0);
    check_eq("b3_busy", busy, 0);

    // Saturation: evt_valid held 6 cycles
    p0 = pulse_cnt;
    pend_max = 0;
    for (int i = 0; i < 25; i++) begin
      evt_valid = (i < 6);
      tick();
      if (pending_cnt > pend_max) pend_max = pending_cnt;
      if (i == 3) begin
        check_eq("sat_ready", evt_ready, 0);
        check_eq("sat_ovf_pre", ovf, 0);
      end
      if (i == 4) check_eq("sat_ovf_set", ovf, 1);
      if (i == 5) check_eq("sat_pend_hold", pending_cnt, 3);
    end
    evt_valid = 1'b0;
    check_eq("sat_pend_max", pend_max, 3);
    check_eq("sat_pulses", pulse_cnt - p0, 4);
    check_eq("sat_ovf", ovf, 1);
    check_eq("sat_pend_end", pending_cnt, 0);
`ifdef PACER_DROP_CNT_EN
    check_eq("sat_drop", drop_cnt, 2);
`endif
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("clr_ovf", ovf, 0);
`ifdef PACER_DROP_CNT_EN
    check_eq("clr_drop", drop_cnt, 0);
`endif

    // Accept on the same edge as an emit with pending 2
    evt_valid = 1'b1;
    tick(); tick(); tick();
    evt_valid = 1'b0;
    tick(); tick(); tick();
    check_eq("ae_pend_pre", pending_cnt, 2);
    evt_valid = 1'b1;
    tick();
    check_eq("ae_read", read, 1);
    check_eq("ae_pend", pending_cnt, 2);
    tick();
    check_eq("full_pend", pending_cnt, 3);
    check_eq("full_ready", evt_ready, 0);
    check_eq("full_ovf", ovf, 0);
    tick();
    check_eq("drop_ovf", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    check_eq("drop_clr_ovf", ovf, 1);
`ifdef PACER_DROP_CNT_EN
    check_eq("drop_clr_cnt", drop_cnt, 1);
`endif
    evt_valid = 1'b0;
    tick();
    clr_ovf = 1'b0;
    check_eq("clr_only_ovf", ovf, 0);
`ifdef PACER_DROP_CNT_EN
    check_eq("clr_only_cnt", drop_cnt, 0);
`endif
    check_eq("gap_pend", pending_cnt, 3);
    check_eq("gap_busy", busy, 1);

    // Asynchronous reset mid-GAP
    #1;
    sys_rst_n = 1'b0;
    #1;
    check_eq("arst_read", read, 0);
    check_eq("arst_pend", pending_cnt, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ready", evt_ready, 1);
    #1;
    sys_rst_n = 1'b1;
    pulse_cnt = 0;
    repeat (30) tick();
    check_eq("post_rst_pulses", pulse_cnt, 0);
    check_eq("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
